// File: rtl/rv_ctrl_pkg.sv
// Shared constants, state encoding and decode payload for the R-type issue sequencer.
package rv_ctrl_pkg;

    localparam logic [6:0] OPCODE_OP   = 7'b0110011;
    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RR   = 3'd1,
        ST_EX   = 3'd2,
        ST_FL   = 3'd3,
        ST_WB   = 3'd4
    } state_e;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [3:0] alu_op;
        logic       legal;
    } rtype_dec_t;

endpackage

// File: rtl/rv_rtype_decode.sv
// Combinational RV32I R-type decoder: register fields, ALU op and legality.
module rv_rtype_decode
    import rv_ctrl_pkg::*;
(
    input  logic [31:0] instr_i,
    output rtype_dec_t  dec_o
);

    logic [3:0] op_c;
    logic       legal_c;

    always_comb begin
        op_c    = ALU_ADD;
        legal_c = 1'b0;
        if (instr_i[6:0] == OPCODE_OP) begin
            legal_c = 1'b1;
            case ({instr_i[31:25], instr_i[14:12]})
                {FUNCT7_BASE, 3'b000}: op_c = ALU_ADD;
                {FUNCT7_BASE, 3'b001}: op_c = ALU_SLL;
                {FUNCT7_BASE, 3'b010}: op_c = ALU_SLT;
                {FUNCT7_BASE, 3'b011}: op_c = ALU_SLTU;
                {FUNCT7_BASE, 3'b100}: op_c = ALU_XOR;
                {FUNCT7_BASE, 3'b101}: op_c = ALU_SRL;
                {FUNCT7_BASE, 3'b110}: op_c = ALU_OR;
                {FUNCT7_BASE, 3'b111}: op_c = ALU_AND;
                {FUNCT7_ALT,  3'b000}: op_c = ALU_SUB;
                {FUNCT7_ALT,  3'b101}: op_c = ALU_SRA;
                default: begin
                    op_c    = ALU_ADD;
                    legal_c = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        dec_o        = '0;
        dec_o.rs1    = instr_i[19:15];
        dec_o.rs2    = instr_i[24:20];
        dec_o.rd     = instr_i[11:7];
        dec_o.alu_op = op_c;
        dec_o.legal  = legal_c;
    end

endmodule

// File: rtl/rtype_issue_ctrl.sv
// R-type issue sequencer: IDLE->RR->EX->FL->WB with WB->RR overlap on a new handshake.
// Optional retired-instruction counter built only when RTYPE_ISSUE_PERF_EN is defined.
module rtype_issue_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned RETIRE_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         instr,
    input  logic                instr_valid,
    output logic                instr_ready,
    output logic [4:0]          R_Addr_A,
    output logic [4:0]          R_Addr_B,
    output logic [4:0]          W_Addr,
    output logic [3:0]          ALU_OP,
    output logic                Reg_Write,
    output logic                en_RR,
    output logic                en_F,
    output logic                en_WB,
    output logic                busy,
    output logic                illegal,
    output logic [RETIRE_W-1:0] retired
);

    state_e      state_q, state_d;
    logic [31:0] instr_q;
    logic        seen_q;
    logic        ready_q, busy_q;
    logic        en_rr_q, en_f_q, en_wb_q, reg_write_q;
    logic        accept;
    rtype_dec_t  dec;

    assign accept = instr_valid & ready_q;

    rv_rtype_decode u_decode (
        .instr_i (instr_q),
        .dec_o   (dec)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_RR;
            ST_RR:   state_d = ST_EX;
            ST_EX:   state_d = ST_FL;
            ST_FL:   state_d = ST_WB;
            ST_WB:   state_d = accept ? ST_RR : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Phase enables and strobes are registered from the next state so each is a clean one-cycle pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            instr_q     <= '0;
            seen_q      <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            en_rr_q     <= 1'b0;
            en_f_q      <= 1'b0;
            en_wb_q     <= 1'b0;
            reg_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            if (accept) begin
                instr_q <= instr;
                seen_q  <= 1'b1;
            end
            ready_q     <= (state_d == ST_IDLE) || (state_d == ST_WB);
            busy_q      <= (state_d != ST_IDLE);
            en_rr_q     <= (state_d == ST_RR);
            en_f_q      <= (state_d == ST_FL);
            en_wb_q     <= (state_d == ST_WB);
            reg_write_q <= (state_d == ST_WB) && dec.legal && (dec.rd != 5'd0);
        end
    end

    assign instr_ready = ready_q;
    assign busy        = busy_q;
    assign en_RR       = en_rr_q;
    assign en_F        = en_f_q;
    assign en_WB       = en_wb_q;
    assign Reg_Write   = reg_write_q;
    assign R_Addr_A    = dec.rs1;
    assign R_Addr_B    = dec.rs2;
    assign W_Addr      = dec.rd;
    assign ALU_OP      = dec.alu_op;
    assign illegal     = seen_q & ~dec.legal;

`ifdef RTYPE_ISSUE_PERF_EN
    logic [RETIRE_W-1:0] retired_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q <= '0;
        end else if (reg_write_q) begin
            retired_q <= retired_q + RETIRE_W'(1);
        end
    end

    assign retired = retired_q;
`else
    assign retired = '0;
`endif

endmodule

// File: tb/tb_rtype_issue_ctrl.sv
// Scoreboard bench for rtype_issue_ctrl: stimulus pushes expected decode, a negedge monitor checks phases.
module tb_rtype_issue_ctrl;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [3:0] op;
        logic       ill;
        logic       rw;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [4:0]  R_Addr_A, R_Addr_B, W_Addr;
    logic [3:0]  ALU_OP;
    logic        Reg_Write, en_RR, en_F, en_WB, busy, illegal;
    logic [15:0] retired;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   exp_ret = 0;
    exp_t exp_q[$];
    int   acc_q[$];
    int   acc_log[$];

    rtype_issue_ctrl #(.RETIRE_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .R_Addr_A    (R_Addr_A),
        .R_Addr_B    (R_Addr_B),
        .W_Addr      (W_Addr),
        .ALU_OP      (ALU_OP),
        .Reg_Write   (Reg_Write),
        .en_RR       (en_RR),
        .en_F        (en_F),
        .en_WB       (en_WB),
        .busy        (busy),
        .illegal     (illegal),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: DUT phase with no pending instruction (cycle %0d)", nm, cyc);
    endtask

    // Monitor: phase timing relative to the accept edge, plus field checks at RR and WB.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            chk("enables_exclusive", ((int'(en_RR) + int'(en_F) + int'(en_WB)) > 1) ? 1 : 0, 0);
            chk("reg_write_outside_wb", (Reg_Write && !en_WB) ? 1 : 0, 0);
            if (instr_valid && instr_ready) begin
                acc_q.push_back(cyc);
                acc_log.push_back(cyc);
            end
            if (en_RR) begin
                if (exp_q.size() == 0 || acc_q.size() == 0) unexpected("unexpected_rr");
                else begin
                    chk("rr_latency", cyc - acc_q[0], 1);
                    chk("rr_addr_a", R_Addr_A, exp_q[0].rs1);
                    chk("rr_addr_b", R_Addr_B, exp_q[0].rs2);
                    chk("rr_w_addr", W_Addr, exp_q[0].rd);
                    chk("rr_alu_op", ALU_OP, exp_q[0].op);
                    chk("rr_illegal", illegal, exp_q[0].ill);
                    chk("rr_busy", busy, 1);
                    chk("rr_ready", instr_ready, 0);
                end
            end
            if (en_F) begin
                if (acc_q.size() == 0) unexpected("unexpected_fl");
                else chk("fl_latency", cyc - acc_q[0], 3);
            end
            if (en_WB) begin
                if (exp_q.size() == 0 || acc_q.size() == 0) unexpected("unexpected_wb");
                else begin
                    chk("wb_latency", cyc - acc_q[0], 4);
                    chk("wb_w_addr", W_Addr, exp_q[0].rd);
                    chk("wb_alu_op", ALU_OP, exp_q[0].op);
                    chk("wb_illegal", illegal, exp_q[0].ill);
                    chk("wb_reg_write", Reg_Write, exp_q[0].rw);
                    chk("wb_ready", instr_ready, 1);
                    if (exp_q[0].rw) exp_ret++;
                    void'(exp_q.pop_front());
                    void'(acc_q.pop_front());
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, instr_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_enables"}, {en_RR, en_F, en_WB}, 0);
        chk({tag, "_reg_write"}, Reg_Write, 0);
        chk({tag, "_illegal"}, illegal, 0);
        chk({tag, "_addrs"}, {R_Addr_A, R_Addr_B, W_Addr}, 0);
        chk({tag, "_alu_op"}, ALU_OP, 0);
        chk({tag, "_retired"}, retired, 0);
    endtask

    task automatic wait_accept();
        int n = 0;
        while (!instr_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) unexpected("accept_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 40) unexpected("idle_timeout");
    endtask

    task automatic send_one(input logic [31:0] ins, input exp_t e);
        exp_q.push_back(e);
        instr       = ins;
        instr_valid = 1'b1;
        wait_accept();
        instr_valid = 1'b0;
        wait_idle();
    endtask

    initial begin
        rst         = 1'b1;
        instr       = '0;
        instr_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // {rs1, rs2, rd, alu_op, illegal, reg_write}
        send_one(32'h002081B3, {5'd1, 5'd2, 5'd3, 4'b0000, 1'b0, 1'b1});  // ADD x3,x1,x2
        send_one(32'h407302B3, {5'd6, 5'd7, 5'd5, 4'b1000, 1'b0, 1'b1});  // SUB x5,x6,x7
        send_one(32'h407352B3, {5'd6, 5'd7, 5'd5, 4'b1101, 1'b0, 1'b1});  // SRA x5,x6,x7
        send_one(32'h0062F233, {5'd5, 5'd6, 5'd4, 4'b0111, 1'b0, 1'b1});  // AND x4,x5,x6
        send_one(32'h00208033, {5'd1, 5'd2, 5'd0, 4'b0000, 1'b0, 1'b0});  // ADD x0,x1,x2
        send_one(32'h00108093, {5'd1, 5'd1, 5'd1, 4'b0000, 1'b1, 1'b0});  // ADDI: wrong opcode
        chk("illegal_held_idle", illegal, 1);
        send_one(32'h4062F233, {5'd5, 5'd6, 5'd4, 4'b0000, 1'b1, 1'b0});  // funct7 alt with AND funct3

        // Back-to-back with valid held: second accept lands in the first WB
        exp_q.push_back({5'd1, 5'd2, 5'd3, 4'b0000, 1'b0, 1'b1});
        instr       = 32'h002081B3;
        instr_valid = 1'b1;
        wait_accept();
        exp_q.push_back({5'd10, 5'd11, 5'd9, 4'b0011, 1'b0, 1'b1});      // SLTU x9,x10,x11
        instr = 32'h00B534B3;
        wait_accept();
        instr_valid = 1'b0;
        wait_idle();
        chk("b2b_accept_gap", acc_log[acc_log.size()-1] - acc_log[acc_log.size()-2], 4);

        // Reset while in FL aborts the instruction without a write-back
        exp_q.push_back({5'd1, 5'd2, 5'd3, 4'b0000, 1'b0, 1'b1});
        instr       = 32'h002081B3;
        instr_valid = 1'b1;
        wait_accept();
        instr_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("pre_reset_in_fl", en_F, 1);
        rst = 1'b1;
        exp_q.delete();
        acc_q.delete();
        exp_ret = 0;
        @(posedge clk);
        #1;
        check_reset_outputs("mid_reset");
        rst = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        chk("post_reset_busy", busy, 0);

        send_one(32'h002081B3, {5'd1, 5'd2, 5'd3, 4'b0000, 1'b0, 1'b1});
        send_one(32'h407302B3, {5'd6, 5'd7, 5'd5, 4'b1000, 1'b0, 1'b1});
        send_one(32'h407352B3, {5'd6, 5'd7, 5'd5, 4'b1101, 1'b0, 1'b1});
        chk("pending_empty", exp_q.size(), 0);
`ifdef RTYPE_ISSUE_PERF_EN
        chk("retired_count", retired, exp_ret);
        chk("retired_three", exp_ret, 3);
`else
        chk("retired_tied", retired, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
